// File: rtl/bottling_pkg.sv
// Shared definitions for the bottling line: feeder FSM state encodings,
// fault codes, the jitter LFSR constants and a counter-width helper.
package bottling_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FEED    = 3'd1,
    S_GAP     = 3'd2,
    S_STARVED = 3'd3,
    S_HALT    = 3'd4
  } feeder_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_STARVED = 2'd1,
    FAULT_ESTOP   = 2'd2
  } fault_e;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bit positions 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Bits needed for a down-counter that starts at max_val (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pill_feeder_rise_detect.sv
// rise_detect: registered rising-edge detector.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   sig    - level input
//   rise   - registered one-cycle pulse after sig goes 0 -> 1
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= sig;
      rise <= sig & ~prev;
    end
  end

endmodule

// File: rtl/pill_feeder.sv
// pill_feeder: pill source and bottle-conveyor model for the bottling counter.
// Emits one-cycle pill pulses at a programmed interval, depletes a hopper
// level per pill, and runs a bottle-swap gap on bottle_done.
// Optional feature: define PILL_FEEDER_JITTER_EN to add LFSR jitter
// (0..15 cycles) to each pill interval reload.
// Ports:
//   clk_1khz           - sole clock (1 kHz)
//   switch_clr         - asynchronous active-low reset
//   run                - feeding enabled (level)
//   emergncy_stop      - forces HALT (level, active-high)
//   simu_hopper_stop   - freezes the pill interval counter
//   simu_hopper_add    - rising edge adds REFILL_AMOUNT to the hopper
//   simu_conveyor_stop - freezes the bottle-gap countdown
//   bottle_done        - one-cycle pulse when a bottle is full
//   pill_pulse         - one-cycle pulse per dispensed pill
//   bottle_ready       - high while a bottle sits under the chute
//   hopper_level       - pills remaining in the hopper
//   fault              - 0 none, 1 starved, 2 estop
//   feeder_state       - current FSM state
module pill_feeder
  import bottling_pkg::*;
#(
  parameter int unsigned PILL_PERIOD   = 200,
  parameter int unsigned BOTTLE_GAP    = 500,
  parameter int unsigned HOPPER_CAP    = 255,
  parameter int unsigned REFILL_AMOUNT = 50
) (
  input  logic       clk_1khz,
  input  logic       switch_clr,
  input  logic       run,
  input  logic       emergncy_stop,
  input  logic       simu_hopper_stop,
  input  logic       simu_hopper_add,
  input  logic       simu_conveyor_stop,
  input  logic       bottle_done,
  output logic       pill_pulse,
  output logic       bottle_ready,
  output logic [7:0] hopper_level,
  output logic [1:0] fault,
  output logic [2:0] feeder_state
);

`ifdef PILL_FEEDER_JITTER_EN
  localparam int unsigned RELOAD_MAX = PILL_PERIOD - 1 + 15;
`else
  localparam int unsigned RELOAD_MAX = PILL_PERIOD - 1;
`endif
  localparam int unsigned CNT_W = cnt_width(RELOAD_MAX);
  localparam int unsigned GAP_W = cnt_width(BOTTLE_GAP - 1);

  feeder_state_e    state_q, state_d;
  fault_e           fault_q, fault_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       level_q, level_d;
  logic             pill_q, pill_d;
  logic             ready_q, ready_d;
  logic             refill;
  logic             dec;
  logic [8:0]       level_sum;
  logic [CNT_W-1:0] reload;

  rise_detect u_add_edge (
    .clk   (clk_1khz),
    .rst_n (switch_clr),
    .sig   (simu_hopper_add),
    .rise  (refill)
  );

`ifdef PILL_FEEDER_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign reload = CNT_W'(PILL_PERIOD - 1) + CNT_W'(lfsr_q[3:0]);

  always_comb begin
    lfsr_d = lfsr_q;
    if (pill_d) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) lfsr_q <= LFSR_SEED;
    else             lfsr_q <= lfsr_d;
  end
`else
  assign reload = CNT_W'(PILL_PERIOD - 1);
`endif

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      state_q    <= S_IDLE;
      fault_q    <= FAULT_NONE;
      interval_q <= '0;
      gap_q      <= '0;
      level_q    <= 8'(HOPPER_CAP);
      pill_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      fault_q    <= fault_d;
      interval_q <= interval_d;
      gap_q      <= gap_d;
      level_q    <= level_d;
      pill_q     <= pill_d;
      ready_q    <= ready_d;
    end
  end

  // Priority: estop > bottle_done > pill emission > run deassert.
  always_comb begin
    state_d    = state_q;
    interval_d = interval_q;
    gap_d      = gap_q;
    ready_d    = ready_q;
    pill_d     = 1'b0;
    dec        = 1'b0;

    if (emergncy_stop) begin
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_d    = S_FEED;
            interval_d = reload;
          end
        end
        S_FEED: begin
          if (bottle_done) begin
            state_d = S_GAP;
            ready_d = 1'b0;
            gap_d   = GAP_W'(BOTTLE_GAP - 1);
          end else if (!simu_hopper_stop && interval_q == '0) begin
            if (level_q != '0) begin
              pill_d     = 1'b1;
              dec        = 1'b1;
              interval_d = reload;
            end else begin
              state_d = S_STARVED;
            end
          end else begin
            if (!simu_hopper_stop) interval_d = interval_q - CNT_W'(1);
            if (!run) state_d = S_IDLE;
          end
        end
        S_GAP: begin
          if (!simu_conveyor_stop) begin
            if (gap_q == '0) begin
              ready_d = 1'b1;
              if (run) begin
                state_d    = S_FEED;
                interval_d = reload;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              gap_d = gap_q - GAP_W'(1);
            end
          end
        end
        S_STARVED: begin
          if (level_q != '0) begin
            state_d    = S_FEED;
            interval_d = reload;
          end else if (!run) begin
            state_d = S_IDLE;
          end
        end
        S_HALT: begin
          if (!run) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Fault code follows the state being entered.
    case (state_d)
      S_HALT:    fault_d = FAULT_ESTOP;
      S_STARVED: fault_d = FAULT_STARVED;
      default:   fault_d = FAULT_NONE;
    endcase

    // Pill and refill on the same edge combine before saturating.
    level_sum = {1'b0, level_q} - 9'(dec) + (refill ? 9'(REFILL_AMOUNT) : 9'd0);
    if (level_sum > 9'(HOPPER_CAP)) level_d = 8'(HOPPER_CAP);
    else                            level_d = level_sum[7:0];
  end

  assign pill_pulse   = pill_q;
  assign bottle_ready = ready_q;
  assign hopper_level = level_q;
  assign fault        = fault_q;
  assign feeder_state = state_q;

endmodule

// File: tb/tb_pill_feeder.sv
module tb_pill_feeder;

  logic       clk_1khz;
  logic       switch_clr;
  logic       run;
  logic       emergncy_stop;
  logic       simu_hopper_stop;
  logic       simu_hopper_add;
  logic       simu_conveyor_stop;
  logic       bottle_done;
  logic       pill_pulse;
  logic       bottle_ready;
  logic [7:0] hopper_level;
  logic [1:0] fault;
  logic [2:0] feeder_state;

  pill_feeder #(
    .PILL_PERIOD   (4),
    .BOTTLE_GAP    (6),
    .HOPPER_CAP    (10),
    .REFILL_AMOUNT (3)
  ) dut (
    .clk_1khz           (clk_1khz),
    .switch_clr         (switch_clr),
    .run                (run),
    .emergncy_stop      (emergncy_stop),
    .simu_hopper_stop   (simu_hopper_stop),
    .simu_hopper_add    (simu_hopper_add),
    .simu_conveyor_stop (simu_conveyor_stop),
    .bottle_done        (bottle_done),
    .pill_pulse         (pill_pulse),
    .bottle_ready       (bottle_ready),
    .hopper_level       (hopper_level),
    .fault              (fault),
    .feeder_state       (feeder_state)
  );

  initial clk_1khz = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  // input bits: {run, estop, hopper_stop, hopper_add, conveyor_stop, bottle_done}
  localparam logic [5:0] RUN   = 6'b100000;
  localparam logic [5:0] ESTOP = 6'b010000;
  localparam logic [5:0] HSTOP = 6'b001000;
  localparam logic [5:0] ADD   = 6'b000100;
  localparam logic [5:0] CSTOP = 6'b000010;
  localparam logic [5:0] BDONE = 6'b000001;
  localparam logic [5:0] NONE  = 6'b000000;

  typedef struct {
    string      name;
    int         n;      // cycles to apply inputs before checking
    logic [5:0] in;
    logic       pill;
    logic       ready;
    logic [7:0] level;
    logic [1:0] fault;
    logic [2:0] state;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void v(string name, int n, logic [5:0] in, logic pill,
                            logic ready, logic [7:0] level, logic [1:0] fault,
                            logic [2:0] state);
    vec_t t;
    t.name = name; t.n = n; t.in = in; t.pill = pill; t.ready = ready;
    t.level = level; t.fault = fault; t.state = state;
    vecs.push_back(t);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {18'd0, pill_pulse, bottle_ready, hopper_level, fault, feeder_state};
  endfunction

  function automatic logic [31:0] pack_exp(logic p, logic r, logic [7:0] l,
                                           logic [1:0] f, logic [2:0] s);
    return {18'd0, p, r, l, f, s};
  endfunction

  task automatic drive(logic [5:0] in);
    {run, emergncy_stop, simu_hopper_stop, simu_hopper_add,
     simu_conveyor_stop, bottle_done} = in;
  endtask

  task automatic step();
    @(posedge clk_1khz);
    #1;
  endtask

  initial begin
    int cycles;
    int pulses;

    // name, cycles, inputs, pill, ready, level, fault, state
    v("feed_entry",      1, RUN,         0, 1, 10, 0, 1);
    v("count_down",      3, RUN,         0, 1, 10, 0, 1);
    v("first_pill",      1, RUN,         1, 1,  9, 0, 1);
    v("pulse_width",     1, RUN,         0, 1,  9, 0, 1);
    v("second_pill",     3, RUN,         1, 1,  8, 0, 1);
    v("tenth_pill",     32, RUN,         1, 1,  0, 0, 1);
    v("starved",         4, RUN,         0, 1,  0, 1, 3);
    v("starved_hold",    2, RUN,         0, 1,  0, 1, 3);
    v("add_sampled",     1, RUN | ADD,   0, 1,  0, 1, 3);
    v("refill_apply",    1, RUN | ADD,   0, 1,  3, 1, 3);
    v("starve_exit",     1, RUN,         0, 1,  3, 0, 1);
    v("refeed_wait",     3, RUN,         0, 1,  3, 0, 1);
    v("refeed_pill",     1, RUN,         1, 1,  2, 0, 1);
    v("gap_enter",       1, RUN | BDONE, 0, 0,  2, 0, 2);
    v("gap_low",         5, RUN,         0, 0,  2, 0, 2);
    v("gap_exit",        1, RUN,         0, 1,  2, 0, 1);
    v("gap2_enter",      1, RUN | BDONE, 0, 0,  2, 0, 2);
    v("gap2_run",        1, RUN,         0, 0,  2, 0, 2);
    v("gap2_frozen",     3, RUN | CSTOP, 0, 0,  2, 0, 2);
    v("gap2_low",        4, RUN,         0, 0,  2, 0, 2);
    v("gap2_exit",       1, RUN,         0, 1,  2, 0, 1);
    v("tc_wait",         3, RUN,         0, 1,  2, 0, 1);
    v("tc_bdone",        1, RUN | BDONE, 0, 0,  2, 0, 2);
    v("tc_gap_exit",     6, RUN,         0, 1,  2, 0, 1);
    v("feed_step",       1, RUN,         0, 1,  2, 0, 1);
    v("estop_enter",     1, RUN | ESTOP, 0, 1,  2, 2, 4);
    v("halt_no_pill",    4, RUN | ESTOP, 0, 1,  2, 2, 4);
    v("halt_run_held",   2, RUN,         0, 1,  2, 2, 4);
    v("halt_exit",       1, NONE,        0, 1,  2, 0, 0);
    v("halt2_enter",     1, ESTOP,       0, 1,  2, 2, 4);
    v("halt_add",        1, ESTOP | ADD, 0, 1,  2, 2, 4);
    v("halt_refill",     1, ESTOP,       0, 1,  5, 2, 4);
    v("halt_add2",       1, ESTOP | ADD, 0, 1,  5, 2, 4);
    v("halt_refill2",    1, ESTOP,       0, 1,  8, 2, 4);
    v("halt_add3",       1, ESTOP | ADD, 0, 1,  8, 2, 4);
    v("halt_refill_sat", 1, ESTOP,       0, 1, 10, 2, 4);
    v("idle_again",      1, NONE,        0, 1, 10, 0, 0);
    v("pill_to_9",       5, RUN,         1, 1,  9, 0, 1);
    v("add_at_9",        1, RUN | ADD,   0, 1,  9, 0, 1);
    v("sat_at_10",       1, RUN,         0, 1, 10, 0, 1);
    v("add_tc",          1, RUN | ADD,   0, 1, 10, 0, 1);
    v("pill_plus_refill",1, RUN,         1, 1, 10, 0, 1);
    v("hstop_frozen",    3, RUN | HSTOP, 0, 1, 10, 0, 1);
    v("hstop_wait",      3, RUN,         0, 1, 10, 0, 1);
    v("hstop_pill",      1, RUN,         1, 1,  9, 0, 1);
    v("run_drop",        1, NONE,        0, 1,  9, 0, 0);

    switch_clr = 1'b0;
    drive(NONE);
    step();
    step();
    chk("reset_state", outs(), pack_exp(0, 1, 10, 0, 0));
    switch_clr = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      for (int c = 0; c < vecs[i].n; c++) step();
      chk(vecs[i].name, outs(),
          pack_exp(vecs[i].pill, vecs[i].ready, vecs[i].level,
                   vecs[i].fault, vecs[i].state));
    end

    // Pill latency from FEED entry, bounded wait.
    drive(RUN);
    step();
    chk("lat_feed_entry", 32'(feeder_state), 32'd1);
    cycles = 0;
    while (!pill_pulse && cycles < 20) begin
      step();
      cycles++;
    end
    chk("pill_latency", 32'(cycles), 32'd4);
    chk("lat_level", 32'(hopper_level), 32'd8);

    // bottle_ready low-time measurement, bounded wait.
    drive(RUN | BDONE);
    step();
    drive(RUN);
    cycles = 0;
    while (!bottle_ready && cycles < 30) begin
      cycles++;
      step();
    end
    chk("gap_low_cycles", 32'(cycles), 32'd6);
    chk("gap_back_feed", 32'(feeder_state), 32'd1);

    // Asynchronous reset mid-operation, then quiet release.
    step();
    #3;
    switch_clr = 1'b0;
    #1;
    chk("async_reset", outs(), pack_exp(0, 1, 10, 0, 0));
    drive(NONE);
    step();
    switch_clr = 1'b1;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (pill_pulse) pulses++;
    end
    chk("release_no_pulse", 32'(pulses), 32'd0);
    chk("release_state", outs(), pack_exp(0, 1, 10, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pill_feeder.md
# pill_feeder

Pill feeder and bottle-conveyor model that produces the pill pulses and bottle-ready status the bottling counter consumes. Clocked from the 1 kHz domain, it emits one-cycle `pill_pulse` events at a programmed interval and depletes a hopper-level counter per pill. It honours hopper-stop, conveyor-stop and emergency-stop inputs, and runs a bottle-swap gap whenever the counter reports a full bottle. It replaces manual button pulses as the pill source for the counter.

## Interface
- `PILL_PERIOD`, 200: cycles between pills; must be ≥ 2.
- `BOTTLE_GAP`, 500: cycles the conveyor needs to swap a bottle.
- `HOPPER_CAP`, 255: hopper capacity; must be ≤ 255.
- `REFILL_AMOUNT`, 50: pills added per refill event.
- `clk_1khz`  in  1  sole clock, 1 kHz.
- `switch_clr`  in  1  reset, asynchronous, active-low.
- `run`  in  1  level; feeding enabled (counter asserts it while RUNNING).
- `emergncy_stop`  in  1  level, active-high; forces HALT.
- `simu_hopper_stop`  in  1  level; hopper gate closed, pill interval counter frozen.
- `simu_hopper_add`  in  1  rising edge adds REFILL_AMOUNT to the hopper.
- `simu_conveyor_stop`  in  1  level; freezes the bottle-gap countdown.
- `bottle_done`  in  1  one-cycle pulse from the counter when a bottle is full.
- `pill_pulse`  out  1  one-cycle pulse per dispensed pill.
- `bottle_ready`  out  1  high while a bottle sits under the chute.
- `hopper_level`  out  8  pills remaining in the hopper.
- `fault`  out  2  fault code: 0 = none, 1 = starved, 2 = estop.
- `feeder_state`  out  3  current FSM state, for display and debug.

## Operation
- Reset values:
  - state IDLE
  - `pill_pulse` 0, `bottle_ready` 1, `fault` 0
  - `hopper_level` HOPPER_CAP
  - interval and gap counters 0
  - `simu_hopper_add` edge register 0
- State encodings: IDLE = 0, FEED = 1, GAP = 2, STARVED = 3, HALT = 4.
- IDLE
  - `run` = 1 → FEED; interval counter loads PILL_PERIOD−1.
- FEED
  - The interval counter decrements each cycle while `simu_hopper_stop` = 0.
  - Terminal count (0) with `hopper_level` > 0: `pill_pulse` = 1, `hopper_level` −1, counter reloads.
  - Terminal count with `hopper_level` = 0: → STARVED, `fault` = 1, no pulse.
  - `run` = 0: → IDLE; any pending pill is discarded.
  - `bottle_done`: → GAP, `bottle_ready` = 0, gap counter loads BOTTLE_GAP−1.
- GAP
  - The gap counter decrements while `simu_conveyor_stop` = 0.
  - At 0: `bottle_ready` = 1, then → FEED with the interval counter reloaded, or → IDLE if `run` = 0.
- STARVED
  - `hopper_level` > 0: → FEED with the interval counter reloaded, `fault` = 0.
  - `run` = 0: → IDLE, `fault` = 0.
- HALT
  - Entered from any state when `emergncy_stop` = 1.
  - `pill_pulse` forced 0; `fault` = 2 while in HALT.
  - `bottle_ready` and `hopper_level` are held.
  - Exit to IDLE only when `emergncy_stop` = 0 and `run` = 0, so the operator must drop `run` before resuming.
- Refill
  - A rising edge of `simu_hopper_add` is detected in every state, HALT included.
  - `hopper_level` = min(level + REFILL_AMOUNT, HOPPER_CAP), computed in 9 bits.
- Priority, highest first: `emergncy_stop` > `bottle_done` > pill emission > `run` deassert. A `bottle_done` coincident with terminal count emits no pill.
- `bottle_done` outside FEED is ignored.

## Timing
- All outputs are registered. `pill_pulse` is exactly one cycle wide.
- The first `pill_pulse` occurs PILL_PERIOD cycles after the first FEED cycle; thereafter the spacing is PILL_PERIOD cycles, plus the number of cycles `simu_hopper_stop` is high.
- `hopper_level` decrements on the same edge that raises `pill_pulse`.
- `bottle_ready` is low for BOTTLE_GAP cycles, plus the number of cycles `simu_conveyor_stop` is high.
- Refill is applied one cycle after the edge is sampled.
- A refill edge coincident with a pill applies both changes: net +REFILL_AMOUNT−1, saturated.
- Reset mid-operation: all state returns to the reset values asynchronously; no pulse is emitted on reset release.

## Configuration
- `PILL_FEEDER_JITTER_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8, 6, 5, 4; seed 8'hA5 on reset) steps once per emitted pill.
  - Interval reload = PILL_PERIOD−1 + `lfsr[3:0]`.
  - The interval counter is widened to hold this maximum.
- Undefined: reload is fixed at PILL_PERIOD−1 and no LFSR exists.

## Structure
- Shared package `bottling_pkg` holds:
  - FSM state encodings (IDLE/FEED/GAP/STARVED/HALT)
  - fault codes (NONE/STARVED/ESTOP)
  - the LFSR seed and tap constants
- Sub-module `rise_detect` (registered previous value, one-cycle rising-edge output) for `simu_hopper_add`. The counter block reuses it.

## Test plan
Settings for all scenarios: PILL_PERIOD = 4, BOTTLE_GAP = 6, HOPPER_CAP = 10, REFILL_AMOUNT = 3, jitter off.
1. Release reset, `run` = 1 → `pill_pulse` every 4 cycles, the first 4 cycles after FEED entry; `hopper_level` 10→9→8.
2. Run until the hopper is empty → 10 pulses, then STARVED with `fault` = 1. One `simu_hopper_add` edge → level 3, FEED, next pulse 4 cycles after re-entry.
3. `bottle_done` in FEED → `bottle_ready` low for 6 cycles. Repeat with `simu_conveyor_stop` high for 3 mid-gap cycles → low for 9 cycles.
4. `emergncy_stop` mid-FEED → HALT, `fault` = 2, no pulses. Release with `run` = 1 → stays HALT. `run` = 0 → IDLE, `fault` = 0.
5. `bottle_done` on the terminal-count cycle → no `pill_pulse`, GAP entered, `hopper_level` unchanged.
6. `hopper_level` 9 plus a refill edge → 10 (saturated). Refill edge during HALT → level updates.
